// File: rtl/ysyx_24100006_axi_sram_slave_if.sv
// AXI4-subset bus between the IFU/MEMU arbiter (master) and the SRAM model
// (slave). Carries the AR/R read channels and the AW/W/B write channels.
//   AR: arvalid, arready, araddr, arlen, arsize
//   R : rvalid, rready, rdata, rresp, rlast
//   AW: awvalid, awready, awaddr, awlen, awsize
//   W : wvalid, wready, wdata, wstrb, wlast
//   B : bvalid, bready, bresp
interface ysyx_24100006_axi_sram_slave_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport slave (
        input  arvalid, araddr, arlen, arsize, rready,
        input  awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rdata, rresp, rlast,
        output awready, wready, bvalid, bresp
    );

    modport master (
        output arvalid, araddr, arlen, arsize, rready,
        output awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
        input  arready, rvalid, rdata, rresp, rlast,
        input  awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/ysyx_24100006_axi_sram_slave.sv
// AXI4-subset memory responder modelling main memory as a 32-bit word array.
// Independent read and write FSMs serve INCR bursts; the read path has a
// configurable latency from AR handshake to the first R beat.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of the AR/R/AW/W/B channels
// Parameters: ADDR_BASE (byte address of word 0), DEPTH_WORDS, RD_LATENCY,
// INIT_FILE (memory image name).
// Optional feature: define AXI_SRAM_RAND_DELAY_EN to insert 0..7 pseudo-random
// extra cycles (16-bit LFSR, seed 16'hACE1) before each R beat and before bvalid.
module ysyx_24100006_axi_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LATENCY  = 1,
    parameter string       INIT_FILE   = ""
) (
    input logic clk,
    input logic reset,
    ysyx_24100006_axi_sram_slave_if.slave bus
);
    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN        = 32'(4 * DEPTH_WORDS);
    localparam logic [7:0]  RD_CNT_INIT = (RD_LATENCY > 0) ? 8'(RD_LATENCY - 1) : 8'd0;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    // Returns {in_range, word_index}. The subtraction wraps mod 2^32, so any
    // address below ADDR_BASE lands far above SPAN and reads as out of range.
    function automatic logic [IDX_W:0] decode(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return {(off < SPAN), off[IDX_W+1:2]};
    endfunction

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;

    logic [31:0] r_addr, r_addr_inc, rd_addr_sel;
    logic [7:0]  r_len, r_beat, r_cnt;
    logic [2:0]  r_size;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        ar_fire, r_fire, r_load, r_last, r_stall, r_valid, r_ok;
    logic [IDX_W:0]   r_dec;
    logic [IDX_W-1:0] r_idx;

    logic [31:0] w_addr, w_addr_inc;
    logic [7:0]  w_len, w_beat;
    logic [2:0]  w_size;
    logic        w_err, aw_fire, w_fire, b_fire, w_stall, b_valid, w_ok;
    logic [IDX_W:0]   w_dec;
    logic [IDX_W-1:0] w_idx;

    assign r_addr_inc = r_addr + (32'd1 << r_size);
    assign w_addr_inc = w_addr + (32'd1 << w_size);
    assign r_last     = (r_beat == r_len);

    // rd_addr_sel is the address whose word is captured into rdata_q when a
    // beat is about to be presented; capturing at the edge keeps rdata stable
    // through stalls and returns pre-write data on a same-cycle write.
    assign r_dec = decode(rd_addr_sel);
    assign r_ok  = r_dec[IDX_W];
    assign r_idx = r_dec[IDX_W-1:0];
    assign w_dec = decode(w_addr);
    assign w_ok  = w_dec[IDX_W];
    assign w_idx = w_dec[IDX_W-1:0];

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic [2:0]  r_dly, w_dly;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr  <= 16'hACE1;
            r_dly <= 3'd0;
            w_dly <= 3'd0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (r_load)              r_dly <= lfsr[2:0];
            else if (r_dly != 3'd0)  r_dly <= r_dly - 3'd1;
            if (w_fire && (w_next == W_RESP)) w_dly <= lfsr[5:3];
            else if (w_dly != 3'd0)           w_dly <= w_dly - 3'd1;
        end
    end

    assign r_stall = (r_dly != 3'd0);
    assign w_stall = (w_dly != 3'd0);
`else
    assign r_stall = 1'b0;
    assign w_stall = 1'b0;
`endif

    // Read FSM next state and handshakes
    always_comb begin
        r_next      = r_state;
        ar_fire     = 1'b0;
        r_fire      = 1'b0;
        r_load      = 1'b0;
        rd_addr_sel = r_addr;
        if (!reset) begin
            case (r_state)
                R_IDLE: if (bus.arvalid) begin
                    ar_fire     = 1'b1;
                    rd_addr_sel = bus.araddr;
                    if (RD_LATENCY == 0) begin
                        r_next = R_DATA;
                        r_load = 1'b1;
                    end else begin
                        r_next = R_WAIT;
                    end
                end
                R_WAIT: if (r_cnt == 8'd0) begin
                    r_next = R_DATA;
                    r_load = 1'b1;
                end
                R_DATA: if (!r_stall && bus.rready) begin
                    r_fire = 1'b1;
                    if (r_last) begin
                        r_next = R_IDLE;
                    end else begin
                        r_load      = 1'b1;
                        rd_addr_sel = r_addr_inc;
                    end
                end
                default: r_next = R_IDLE;
            endcase
        end
    end

    // Write FSM next state and handshakes
    always_comb begin
        w_next  = w_state;
        aw_fire = 1'b0;
        w_fire  = 1'b0;
        b_fire  = 1'b0;
        if (!reset) begin
            case (w_state)
                W_IDLE: if (bus.awvalid) begin
                    aw_fire = 1'b1;
                    w_next  = W_DATA;
                end
                W_DATA: if (bus.wvalid) begin
                    w_fire = 1'b1;
                    if (bus.wlast || (w_beat == w_len)) w_next = W_RESP;
                end
                W_RESP: if (!w_stall && bus.bready) begin
                    b_fire = 1'b1;
                    w_next = W_IDLE;
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    // Beat/latency counters and sticky write error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat <= 8'd0;
            r_cnt  <= 8'd0;
            w_beat <= 8'd0;
            w_err  <= 1'b0;
        end else begin
            if (ar_fire) begin
                r_beat <= 8'd0;
                r_cnt  <= RD_CNT_INIT;
            end else begin
                if ((r_state == R_WAIT) && (r_cnt != 8'd0)) r_cnt <= r_cnt - 8'd1;
                if (r_fire) r_beat <= r_beat + 8'd1;
            end
            if (aw_fire) begin
                w_beat <= 8'd0;
                w_err  <= 1'b0;
            end else if (w_fire) begin
                w_beat <= w_beat + 8'd1;
                if (!w_ok) w_err <= 1'b1;
            end
        end
    end

    // Burst address tracking and memory array
    always_ff @(posedge clk) begin
        if (ar_fire) begin
            r_addr <= bus.araddr;
            r_len  <= bus.arlen;
            r_size <= bus.arsize;
        end else if (r_fire && !r_last) begin
            r_addr <= r_addr_inc;
        end
        if (aw_fire) begin
            w_addr <= bus.awaddr;
            w_len  <= bus.awlen;
            w_size <= bus.awsize;
        end else if (w_fire) begin
            w_addr <= w_addr_inc;
        end
        if (r_load) begin
            rdata_q <= r_ok ? mem[r_idx] : 32'd0;
            rresp_q <= r_ok ? 2'b00 : 2'b10;
        end
        if (w_fire && w_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign r_valid     = !reset && (r_state == R_DATA) && !r_stall;
    assign b_valid     = !reset && (w_state == W_RESP) && !w_stall;

    assign bus.arready = !reset && (r_state == R_IDLE);
    assign bus.rvalid  = r_valid;
    assign bus.rdata   = r_valid ? rdata_q : 32'd0;
    assign bus.rresp   = r_valid ? rresp_q : 2'b00;
    assign bus.rlast   = r_valid && r_last;

    assign bus.awready = !reset && (w_state == W_IDLE);
    assign bus.wready  = !reset && (w_state == W_DATA);
    assign bus.bvalid  = b_valid;
    assign bus.bresp   = (b_valid && w_err) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_ysyx_24100006_axi_sram_slave.sv
// Self-checking bench for ysyx_24100006_axi_sram_slave (default build,
// RD_LATENCY=1). Read beats are predicted into a scoreboard queue from a
// bench-side memory model when AR is driven and popped as R beats complete;
// write responses go through a second queue.
`timescale 1ns/1ps
module tb_ysyx_24100006_axi_sram_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] SPAN  = 32'h0000_4000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ysyx_24100006_axi_sram_slave_if bus ();

    ysyx_24100006_axi_sram_slave #(
        .ADDR_BASE  (BASE),
        .DEPTH_WORDS(DEPTH),
        .RD_LATENCY (1),
        .INIT_FILE  ("")
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model  [DEPTH];
    logic [31:0] wd_buf [256];
    logic [3:0]  ws_buf [256];

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic [2:0]  size;
        bit          tog;
        int          exp_lat;
        logic [1:0]  exp_resp0;
        bit          chk_d0;
        logic [31:0] exp_d0;
    } rvec_t;

    rbeat_t     rq [$];
    logic [1:0] bq [$];
    rvec_t      rv [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] exp_rd(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off < SPAN) return {2'b00, model[off[13:2]]};
        return {2'b10, 32'd0};
    endfunction

    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input bit tog, input int exp_lat, input logic [1:0] exp_resp0,
                           input bit chk_d0, input logic [31:0] exp_d0);
        logic [31:0] a;
        logic [33:0] m;
        rbeat_t      e;
        int          beats, cyc, lat;
        bit          held;
        logic [31:0] hd;
        logic        hl;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            m = exp_rd(a);
            e.data = m[31:0];
            e.resp = m[33:32];
            e.last = (i == len);
            rq.push_back(e);
            a = a + (32'd1 << size);
        end
        bus.araddr  = addr;
        bus.arlen   = 8'(len);
        bus.arsize  = size;
        bus.arvalid = 1'b1;
        cyc = 0;
        while (!bus.arready && cyc < 100) begin
            step();
            cyc++;
        end
        if (!bus.arready) begin
            chk("ar_handshake_timeout", bus.arready, 1'b1);
            bus.arvalid = 1'b0;
            rq.delete();
            return;
        end
        step();
        bus.arvalid = 1'b0;
        beats = 0;
        cyc   = 0;
        lat   = -1;
        held  = 1'b0;
        while (beats <= len && cyc < 3000) begin
            bus.rready = tog ? ~cyc[0] : 1'b1;
            if (held) begin
                chk("r_hold_valid", bus.rvalid, 1'b1);
                chk("r_hold_data", bus.rdata, hd);
                chk("r_hold_last", bus.rlast, hl);
            end
            held = 1'b0;
            if (bus.rvalid && lat < 0) begin
                lat = cyc + 1;
                chk("r_latency", lat, exp_lat);
                chk("r_resp_first", bus.rresp, exp_resp0);
                if (chk_d0) chk("r_data_first", bus.rdata, exp_d0);
            end
            if (lat >= 0 && !tog) chk("r_no_bubble", bus.rvalid, 1'b1);
            if (bus.rvalid) begin
                if (bus.rready) begin
                    e = rq.pop_front();
                    chk("r_data", bus.rdata, e.data);
                    chk("r_resp", bus.rresp, e.resp);
                    chk("r_last", bus.rlast, e.last);
                    beats++;
                end else begin
                    held = 1'b1;
                    hd   = bus.rdata;
                    hl   = bus.rlast;
                end
            end
            step();
            cyc++;
        end
        bus.rready = 1'b0;
        if (beats <= len) begin
            n_cmp++;
            n_err++;
            $display("FAIL r_beats_timeout: got %0d beats expected %0d", beats, len + 1);
            rq.delete();
        end else begin
            chk("arready_after_last", bus.arready, 1'b1);
            chk("rvalid_after_last", bus.rvalid, 1'b0);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size);
        logic [31:0] a, off;
        logic [1:0]  eresp;
        int          n;
        eresp = 2'b00;
        a     = addr;
        bus.awaddr  = addr;
        bus.awlen   = 8'(len);
        bus.awsize  = size;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.wdata   = wd_buf[0];
        bus.wstrb   = ws_buf[0];
        bus.wlast   = (len == 0);
        n = 0;
        while (!bus.awready && n < 100) begin
            step();
            n++;
        end
        if (!bus.awready) begin
            chk("aw_handshake_timeout", bus.awready, 1'b1);
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            return;
        end
        chk("wready_before_aw", bus.wready, 1'b0);
        step();
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = wd_buf[i];
            bus.wstrb  = ws_buf[i];
            bus.wlast  = (i == len);
            n = 0;
            while (!bus.wready && n < 100) begin
                step();
                n++;
            end
            if (!bus.wready) begin
                chk("w_beat_timeout", bus.wready, 1'b1);
                bus.wvalid = 1'b0;
                return;
            end
            off = a - BASE;
            if (off < SPAN) begin
                for (int b = 0; b < 4; b++) begin
                    if (ws_buf[i][b]) model[off[13:2]][8*b +: 8] = wd_buf[i][8*b +: 8];
                end
            end else begin
                eresp = 2'b10;
            end
            step();
            a = a + (32'd1 << size);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        bq.push_back(eresp);
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 100) begin
            step();
            n++;
        end
        if (!bus.bvalid) begin
            chk("b_timeout", bus.bvalid, 1'b1);
            void'(bq.pop_front());
        end else begin
            chk("bresp", bus.bresp, bq.pop_front());
            step();
            chk("awready_after_b", bus.awready, 1'b1);
        end
        bus.bready = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rb, cyc;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.rready = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0; bus.wlast  = 1'b0; bus.bready = 1'b0;

        // Vectors: addr, len, size, rready toggle, latency, first rresp, check/expect first rdata
        rv[0] = '{BASE,                 0, 3'd2, 1'b0, 2, 2'b00, 1'b1, 32'hDEAD_BEEF};
        rv[1] = '{BASE + 32'h10,        3, 3'd2, 1'b1, 2, 2'b00, 1'b1, 32'h1404_0404};
        rv[2] = '{BASE,                 3, 3'd0, 1'b0, 2, 2'b00, 1'b1, 32'hDEAD_BEEF};
        rv[3] = '{BASE + 32'h4,         7, 3'd1, 1'b1, 2, 2'b00, 1'b1, 32'h1101_0101};
        rv[4] = '{BASE + SPAN - 32'h4,  1, 3'd2, 1'b0, 2, 2'b00, 1'b1, 32'hCAFE_F00D};
        rv[5] = '{32'hFFFF_FFFC,        1, 3'd2, 1'b0, 2, 2'b10, 1'b1, 32'h0};
        rv[6] = '{BASE + SPAN,          0, 3'd2, 1'b0, 2, 2'b10, 1'b1, 32'h0};

        repeat (2) step();
        chk("rst_arready", bus.arready, 1'b0);
        chk("rst_rvalid",  bus.rvalid,  1'b0);
        chk("rst_awready", bus.awready, 1'b0);
        chk("rst_wready",  bus.wready,  1'b0);
        chk("rst_bvalid",  bus.bvalid,  1'b0);
        chk("rst_rdata",   bus.rdata,   32'd0);
        chk("rst_rlast",   bus.rlast,   1'b0);
        chk("rst_rresp",   bus.rresp,   2'b00);
        chk("rst_bresp",   bus.bresp,   2'b00);
        reset = 1'b0;
        step();
        chk("idle_arready", bus.arready, 1'b1);
        chk("idle_awready", bus.awready, 1'b1);
        chk("idle_wready",  bus.wready,  1'b0);

        for (int i = 0; i < 16; i++) begin
            wd_buf[i] = (i == 0) ? 32'hDEAD_BEEF : 32'h1000_0000 + i * 32'h0101_0101;
            ws_buf[i] = 4'hF;
        end
        do_write(BASE, 15, 3'd2);
        wd_buf[0] = 32'hCAFE_F00D;
        do_write(BASE + SPAN - 32'h4, 0, 3'd2);

        for (int v = 0; v < 7; v++) begin
            do_read(rv[v].addr, rv[v].len, rv[v].size, rv[v].tog, rv[v].exp_lat,
                    rv[v].exp_resp0, rv[v].chk_d0, rv[v].exp_d0);
        end

        // Single-byte strobe write to lane 3
        wd_buf[0] = 32'hAB00_0000;
        ws_buf[0] = 4'b1000;
        do_write(BASE + 32'h3, 0, 3'd0);
        do_read(BASE, 0, 3'd2, 1'b0, 2, 2'b00, 1'b1, 32'hABAD_BEEF);

        // Out-of-range write must not alias into the array
        wd_buf[0] = 32'h5555_5555;
        ws_buf[0] = 4'hF;
        do_write(BASE + SPAN, 0, 3'd2);
        do_read(BASE, 0, 3'd2, 1'b0, 2, 2'b00, 1'b1, 32'hABAD_BEEF);

        // Full 256-beat bursts
        for (int i = 0; i < 256; i++) begin
            wd_buf[i] = {8'(i), 8'hA5, ~8'(i), 8'h3C};
            ws_buf[i] = 4'hF;
        end
        do_write(BASE + 32'h400, 255, 3'd2);
        do_read(BASE + 32'h400, 255, 3'd2, 1'b0, 2, 2'b00, 1'b1, 32'h00A5_FF3C);

        // Concurrent read and write to disjoint ranges
        for (int i = 0; i < 4; i++) begin
            wd_buf[i] = 32'h7700_0000 + i;
            ws_buf[i] = 4'hF;
        end
        fork
            do_read(BASE + 32'h10, 3, 3'd2, 1'b0, 2, 2'b00, 1'b1, 32'h1404_0404);
            do_write(BASE + 32'h100, 3, 3'd2);
        join
        do_read(BASE + 32'h100, 3, 3'd2, 1'b1, 2, 2'b00, 1'b1, 32'h7700_0000);

        // Reset in the middle of concurrent bursts
        bus.araddr = BASE; bus.arlen = 8'd3; bus.arsize = 3'd2; bus.arvalid = 1'b1;
        bus.awaddr = BASE + 32'h200; bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awvalid = 1'b1;
        bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        bus.rready = 1'b1; bus.bready = 1'b1;
        chk("mid_arready", bus.arready, 1'b1);
        chk("mid_awready", bus.awready, 1'b1);
        step();
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        rb = 0;
        cyc = 0;
        while (rb < 2 && cyc < 50) begin
            if (bus.rvalid) rb++;
            step();
            cyc++;
        end
        chk("mid_two_beats", rb, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_arready", bus.arready, 1'b0);
        chk("mid_rst_rvalid",  bus.rvalid,  1'b0);
        chk("mid_rst_awready", bus.awready, 1'b0);
        chk("mid_rst_wready",  bus.wready,  1'b0);
        chk("mid_rst_bvalid",  bus.bvalid,  1'b0);
        chk("mid_rst_rdata",   bus.rdata,   32'd0);
        step();
        reset = 1'b0;
        bus.wvalid = 1'b0;
        #1;
        chk("post_rst_arready", bus.arready, 1'b1);
        chk("post_rst_awready", bus.awready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_rvalid", bus.rvalid, 1'b0);
            chk("post_rst_bvalid", bus.bvalid, 1'b0);
            step();
        end
        bus.rready = 1'b0;
        bus.bready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
